avalon_pkt_stats: RTL and testbench

- Downstream consumer of the packet sorter's Avalon-ST source.
- Accepts one packet at a time and reduces it to a single statistics record: min, max, sum, length, order check, truncation flag.
- Presents the record on a valid/ready result interface.
- Stalls the upstream sorter while a result is waiting to be taken.

---
 rtl/avalon_pkt_stats_pkg.sv | 34 +++
 rtl/avalon_pkt_stats_update.sv | 43 ++++
 rtl/avalon_pkt_stats.sv | 138 +++++++++++++
 tb/tb_avalon_pkt_stats.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_pkt_stats_pkg.sv
// Shared types and width helpers for the Avalon-ST packet statistics block.
package avalon_pkt_stats_pkg;

   localparam int PKT_DWIDTH  = 4;
   localparam int PKT_MAX_LEN = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   function automatic int len_w(input int max_len);
      return $clog2(max_len + 32'd1);
   endfunction

   function automatic int sum_w(input int dw, input int max_len);
      return dw + len_w(max_len);
   endfunction

   localparam int PKT_LEN_W = len_w(PKT_MAX_LEN);
   localparam int PKT_SUM_W = sum_w(PKT_DWIDTH, PKT_MAX_LEN);

   // Record widths follow the package defaults, which the top-level parameters default to.
   typedef struct packed {
      logic [PKT_DWIDTH-1:0] min;
      logic [PKT_DWIDTH-1:0] max;
      logic [PKT_SUM_W-1:0]  sum;
      logic [PKT_LEN_W-1:0]  len;
      logic                  sorted;
      logic                  trunc;
   } stats_t;

endpackage

// File: rtl/avalon_pkt_stats_update.sv
// Combinational next-accumulator: folds one data word into the running packet statistics.
module pkt_stats_update
   import avalon_pkt_stats_pkg::*;
#(
   parameter int DWIDTH      = PKT_DWIDTH,
   parameter int MAX_PKT_LEN = PKT_MAX_LEN
) (
   input  stats_t            cur_stats,
   input  logic [DWIDTH-1:0] prev,
   input  logic [DWIDTH-1:0] data,
   input  logic              first_beat,
   output stats_t            nxt_stats,
   output logic [DWIDTH-1:0] nxt_prev
);

   localparam int LEN_W = len_w(MAX_PKT_LEN);
   localparam int SUM_W = sum_w(DWIDTH, MAX_PKT_LEN);

   // Start a fresh record, fold a counted beat, or freeze and flag truncation
   always_comb begin
      nxt_stats = cur_stats;
      nxt_prev  = prev;
      if (first_beat) begin
         nxt_stats.min    = data;
         nxt_stats.max    = data;
         nxt_stats.sum    = SUM_W'(data);
         nxt_stats.len    = LEN_W'(1'b1);
         nxt_stats.sorted = 1'b1;
         nxt_stats.trunc  = 1'b0;
         nxt_prev         = data;
      end else if (cur_stats.len < LEN_W'(MAX_PKT_LEN)) begin
         nxt_stats.min    = (data < cur_stats.min) ? data : cur_stats.min;
         nxt_stats.max    = (data > cur_stats.max) ? data : cur_stats.max;
         nxt_stats.sum    = cur_stats.sum + SUM_W'(data);
         nxt_stats.len    = cur_stats.len + LEN_W'(1'b1);
         nxt_stats.sorted = cur_stats.sorted & (data >= prev);
         nxt_prev         = data;
      end else begin
         nxt_stats.trunc  = 1'b1;
      end
   end

endmodule

// File: rtl/avalon_pkt_stats.sv
// Reduces one Avalon-ST packet at a time to a statistics record on a valid/ready port.
// Define STATS_ERR_CNT_EN to add err_cnt_o, a saturating protocol error counter.
module avalon_pkt_stats
   import avalon_pkt_stats_pkg::*;
#(
   parameter int  DWIDTH      = PKT_DWIDTH,
   parameter int  MAX_PKT_LEN = PKT_MAX_LEN,
   localparam int LEN_W       = len_w(MAX_PKT_LEN),
   localparam int SUM_W       = sum_w(DWIDTH, MAX_PKT_LEN)
) (
   input  logic              clk_i,
   input  logic              srst_n_i,
   input  logic [DWIDTH-1:0] snk_data_i,
   input  logic              snk_valid_i,
   input  logic              snk_startofpacket_i,
   input  logic              snk_endofpacket_i,
   output logic              snk_ready_o,
   output logic [DWIDTH-1:0] stat_min_o,
   output logic [DWIDTH-1:0] stat_max_o,
   output logic [SUM_W-1:0]  stat_sum_o,
   output logic [LEN_W-1:0]  stat_len_o,
   output logic              stat_sorted_o,
   output logic              stat_trunc_o,
   output logic              stat_valid_o,
   input  logic              stat_ready_i
`ifdef STATS_ERR_CNT_EN
   ,
   output logic [15:0]       err_cnt_o
`endif
);

   state_t            state_r;
   stats_t            acc_r;
   stats_t            stat_r;
   stats_t            upd_stats_s;
   logic [DWIDTH-1:0] prev_r;
   logic [DWIDTH-1:0] upd_prev_s;
   logic              snk_ready_r;
   logic              stat_valid_r;
   logic              accept_s;

   assign accept_s = snk_valid_i & snk_ready_r;

   pkt_stats_update #(
      .DWIDTH      (DWIDTH),
      .MAX_PKT_LEN (MAX_PKT_LEN)
   ) u_update (
      .cur_stats  (acc_r),
      .prev       (prev_r),
      .data       (snk_data_i),
      .first_beat (snk_startofpacket_i),
      .nxt_stats  (upd_stats_s),
      .nxt_prev   (upd_prev_s)
   );

   // Packet FSM with accumulators and the registered ready/result outputs
   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         state_r      <= IDLE;
         acc_r        <= '0;
         prev_r       <= '0;
         stat_r       <= '0;
         stat_valid_r <= 1'b0;
         snk_ready_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE, ACCUM: begin
               snk_ready_r <= 1'b1;
               // An SOP beat always (re)starts a packet; a non-SOP beat in IDLE is an orphan and dropped
               if (accept_s && (snk_startofpacket_i || (state_r == ACCUM))) begin
                  acc_r  <= upd_stats_s;
                  prev_r <= upd_prev_s;
                  if (snk_endofpacket_i) begin
                     state_r      <= HOLD;
                     stat_r       <= upd_stats_s;
                     stat_valid_r <= 1'b1;
                     snk_ready_r  <= 1'b0;
                  end else begin
                     state_r <= ACCUM;
                  end
               end
            end
            HOLD: begin
               if (stat_ready_i) begin
                  state_r      <= IDLE;
                  stat_valid_r <= 1'b0;
                  snk_ready_r  <= 1'b1;
               end
            end
            default: begin
               state_r      <= IDLE;
               stat_valid_r <= 1'b0;
               snk_ready_r  <= 1'b1;
            end
         endcase
      end
   end

   assign snk_ready_o   = snk_ready_r;
   assign stat_valid_o  = stat_valid_r;
   assign stat_min_o    = stat_r.min;
   assign stat_max_o    = stat_r.max;
   assign stat_sum_o    = stat_r.sum;
   assign stat_len_o    = stat_r.len;
   assign stat_sorted_o = stat_r.sorted;
   assign stat_trunc_o  = stat_r.trunc;

`ifdef STATS_ERR_CNT_EN
   logic        err_evt_s;
   logic [15:0] err_cnt_r;

   // One error event per cycle: orphan beat, restart on SOP, or loading a truncated result
   always_comb begin
      err_evt_s = 1'b0;
      if (accept_s) begin
         case (state_r)
            IDLE:    err_evt_s = ~snk_startofpacket_i;
            ACCUM:   err_evt_s = snk_startofpacket_i | (snk_endofpacket_i & upd_stats_s.trunc);
            default: err_evt_s = 1'b0;
         endcase
      end else begin
         err_evt_s = 1'b0;
      end
   end

   // Saturating error counter
   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         err_cnt_r <= 16'd0;
      end else if (err_evt_s && (err_cnt_r != 16'hFFFF)) begin
         err_cnt_r <= err_cnt_r + 16'd1;
      end
   end

   assign err_cnt_o = err_cnt_r;
`endif

endmodule

// File: tb/tb_avalon_pkt_stats.sv
// Self-checking bench for avalon_pkt_stats: directed scenarios plus randomized packets vs a list model.
module tb_avalon_pkt_stats;

   localparam int MAXL = 5;

   logic        clk_i = 1'b0;
   logic        srst_n_i;
   logic [3:0]  snk_data_i;
   logic        snk_valid_i;
   logic        snk_startofpacket_i;
   logic        snk_endofpacket_i;
   logic        snk_ready_o;
   logic [3:0]  stat_min_o;
   logic [3:0]  stat_max_o;
   logic [6:0]  stat_sum_o;
   logic [2:0]  stat_len_o;
   logic        stat_sorted_o;
   logic        stat_trunc_o;
   logic        stat_valid_o;
   logic        stat_ready_i;
   logic [15:0] err_obs;
   logic [19:0] rec_obs;
   logic [37:0] outs_obs;

   int checks  = 0;
   int passed  = 0;
   int exp_err = 0;

`ifdef STATS_ERR_CNT_EN
   logic [15:0] err_cnt_o;
   assign err_obs = err_cnt_o;
`else
   assign err_obs = 16'd0;
`endif

   assign rec_obs  = {stat_min_o, stat_max_o, stat_sum_o, stat_len_o, stat_sorted_o, stat_trunc_o};
   assign outs_obs = {snk_ready_o, stat_valid_o, rec_obs, err_obs};

   always #5 clk_i = ~clk_i;

   avalon_pkt_stats dut (
      .clk_i               (clk_i),
      .srst_n_i            (srst_n_i),
      .snk_data_i          (snk_data_i),
      .snk_valid_i         (snk_valid_i),
      .snk_startofpacket_i (snk_startofpacket_i),
      .snk_endofpacket_i   (snk_endofpacket_i),
      .snk_ready_o         (snk_ready_o),
      .stat_min_o          (stat_min_o),
      .stat_max_o          (stat_max_o),
      .stat_sum_o          (stat_sum_o),
      .stat_len_o          (stat_len_o),
      .stat_sorted_o       (stat_sorted_o),
      .stat_trunc_o        (stat_trunc_o),
      .stat_valid_o        (stat_valid_o),
      .stat_ready_i        (stat_ready_i)
`ifdef STATS_ERR_CNT_EN
      ,
      .err_cnt_o           (err_cnt_o)
`endif
   );

   // Reference record: statistics over the first MAXL words of the packet
   function automatic logic [19:0] model_rec(input int words[$]);
      int n;
      int mn;
      int mx;
      int sm;
      bit srt;
      n   = (words.size() > MAXL) ? MAXL : words.size();
      mn  = words[0];
      mx  = words[0];
      sm  = 0;
      srt = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (words[i] < mn) mn = words[i];
         if (words[i] > mx) mx = words[i];
         sm += words[i];
         if (i > 0 && words[i] < words[i-1]) srt = 1'b0;
      end
      return {4'(mn), 4'(mx), 7'(sm), 3'(n), srt, (words.size() > MAXL)};
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Present one beat and hold it until the DUT accepts it (bounded)
   task automatic drive_beat(input logic [3:0] d, input logic sop, input logic eop);
      int n;
      n = 0;
      snk_data_i          = d;
      snk_startofpacket_i = sop;
      snk_endofpacket_i   = eop;
      snk_valid_i         = 1'b1;
      while (snk_ready_o !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      if (n >= 40) begin
         checks++;
         $display("FAIL beat_accept_timeout ready=%b required=1", snk_ready_o);
      end
      tick();
      snk_valid_i         = 1'b0;
      snk_startofpacket_i = 1'b0;
      snk_endofpacket_i   = 1'b0;
   endtask

   task automatic send_pkt(input int words[$], input int max_gap);
      int g;
      for (int i = 0; i < words.size(); i++) begin
         g = $urandom_range(max_gap, 0);
         repeat (g) tick();
         drive_beat(4'(words[i]), (i == 0), (i == words.size() - 1));
      end
   endtask

   task automatic test_reset();
      srst_n_i = 1'b0;
      repeat (3) tick();
      checks++;
      if (outs_obs !== 38'd0) $display("FAIL reset_outputs got=%h required=0", outs_obs);
      else passed++;
      srst_n_i = 1'b1;
      tick();
      checks++;
      if ({snk_ready_o, stat_valid_o} !== 2'b10)
         $display("FAIL ready_after_reset got=%b required=10", {snk_ready_o, stat_valid_o});
      else passed++;
   endtask

   task automatic test_sorted();
      int w[$];
      w = '{1, 3, 3, 7, 9};
      send_pkt(w, 0);
      checks++;
      if ({stat_valid_o, snk_ready_o, rec_obs} !== {1'b1, 1'b0, 4'd1, 4'd9, 7'd23, 3'd5, 1'b1, 1'b0})
         $display("FAIL sorted_result got=%b_%b_%h required=1_0_%h", stat_valid_o, snk_ready_o, rec_obs,
                  {4'd1, 4'd9, 7'd23, 3'd5, 1'b1, 1'b0});
      else passed++;
      tick();
      checks++;
      if ({stat_valid_o, snk_ready_o} !== 2'b01)
         $display("FAIL ready_gap got=%b required=01", {stat_valid_o, snk_ready_o});
      else passed++;
   endtask

   task automatic test_unsorted_single();
      int w[$];
      w = '{4, 2, 5};
      send_pkt(w, 1);
      checks++;
      if ({stat_valid_o, rec_obs} !== {1'b1, 4'd2, 4'd5, 7'd11, 3'd3, 1'b0, 1'b0})
         $display("FAIL unsorted_result got=%b_%h required=1_%h", stat_valid_o, rec_obs,
                  {4'd2, 4'd5, 7'd11, 3'd3, 1'b0, 1'b0});
      else passed++;
      tick();
      w = '{6};
      send_pkt(w, 0);
      checks++;
      if ({stat_valid_o, rec_obs} !== {1'b1, 4'd6, 4'd6, 7'd6, 3'd1, 1'b1, 1'b0})
         $display("FAIL single_beat got=%b_%h required=1_%h", stat_valid_o, rec_obs,
                  {4'd6, 4'd6, 7'd6, 3'd1, 1'b1, 1'b0});
      else passed++;
      tick();
   endtask

   task automatic test_trunc();
      int w[$];
      w = '{1, 2, 3, 4, 5, 6, 7};
      send_pkt(w, 1);
      exp_err++;
      checks++;
      if ({stat_valid_o, rec_obs} !== {1'b1, 4'd1, 4'd5, 7'd15, 3'd5, 1'b1, 1'b1})
         $display("FAIL trunc_result got=%b_%h required=1_%h", stat_valid_o, rec_obs,
                  {4'd1, 4'd5, 7'd15, 3'd5, 1'b1, 1'b1});
      else passed++;
`ifdef STATS_ERR_CNT_EN
      checks++;
      if (err_obs !== 16'(exp_err)) $display("FAIL trunc_err_cnt got=%0d required=%0d", err_obs, exp_err);
      else passed++;
`endif
      tick();
   endtask

   task automatic test_backpressure();
      int w[$];
      stat_ready_i = 1'b0;
      w = '{2, 6};
      send_pkt(w, 0);
      snk_data_i          = 4'd3;
      snk_startofpacket_i = 1'b1;
      snk_valid_i         = 1'b1;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({stat_valid_o, snk_ready_o, rec_obs} !== {1'b1, 1'b0, 4'd2, 4'd6, 7'd8, 3'd2, 1'b1, 1'b0})
            $display("FAIL hold_stable cyc=%0d got=%b_%b_%h required=1_0_%h", i, stat_valid_o, snk_ready_o,
                     rec_obs, {4'd2, 4'd6, 7'd8, 3'd2, 1'b1, 1'b0});
         else passed++;
         tick();
      end
      stat_ready_i = 1'b1;
      tick();
      checks++;
      if ({stat_valid_o, snk_ready_o} !== 2'b01)
         $display("FAIL hold_release got=%b required=01", {stat_valid_o, snk_ready_o});
      else passed++;
      tick();
      snk_startofpacket_i = 1'b0;
      snk_endofpacket_i   = 1'b1;
      snk_data_i          = 4'd8;
      tick();
      snk_valid_i       = 1'b0;
      snk_endofpacket_i = 1'b0;
      checks++;
      if ({stat_valid_o, rec_obs} !== {1'b1, 4'd3, 4'd8, 7'd11, 3'd2, 1'b1, 1'b0})
         $display("FAIL after_release_pkt got=%b_%h required=1_%h", stat_valid_o, rec_obs,
                  {4'd3, 4'd8, 7'd11, 3'd2, 1'b1, 1'b0});
      else passed++;
      tick();
   endtask

   task automatic test_protocol();
      drive_beat(4'd5, 1'b0, 1'b0);
      drive_beat(4'd2, 1'b1, 1'b0);
      drive_beat(4'd8, 1'b1, 1'b0);
      drive_beat(4'd9, 1'b0, 1'b1);
      exp_err += 2;
      checks++;
      if ({stat_valid_o, rec_obs} !== {1'b1, 4'd8, 4'd9, 7'd17, 3'd2, 1'b1, 1'b0})
         $display("FAIL protocol_result got=%b_%h required=1_%h", stat_valid_o, rec_obs,
                  {4'd8, 4'd9, 7'd17, 3'd2, 1'b1, 1'b0});
      else passed++;
`ifdef STATS_ERR_CNT_EN
      checks++;
      if (err_obs !== 16'(exp_err)) $display("FAIL protocol_err_cnt got=%0d required=%0d", err_obs, exp_err);
      else passed++;
`endif
      tick();
   endtask

   task automatic test_random();
      int          w[$];
      int          len;
      logic [19:0] exp;
      for (int p = 0; p < 25; p++) begin
         len = $urandom_range(8, 1);
         w.delete();
         for (int i = 0; i < len; i++) w.push_back($urandom_range(15, 0));
         exp = model_rec(w);
         if (len > MAXL) exp_err++;
         stat_ready_i = 1'($urandom_range(1, 0));
         send_pkt(w, 2);
         checks++;
         if ({stat_valid_o, rec_obs} !== {1'b1, exp})
            $display("FAIL random_pkt%0d len=%0d got=%b_%h required=1_%h", p, len, stat_valid_o, rec_obs, exp);
         else passed++;
         if (stat_ready_i !== 1'b1) begin
            repeat ($urandom_range(3, 1)) tick();
            stat_ready_i = 1'b1;
         end
         tick();
      end
`ifdef STATS_ERR_CNT_EN
      checks++;
      if (err_obs !== 16'(exp_err)) $display("FAIL random_err_cnt got=%0d required=%0d", err_obs, exp_err);
      else passed++;
`endif
   endtask

   task automatic test_reset_mid();
      int w[$];
      drive_beat(4'd4, 1'b1, 1'b0);
      drive_beat(4'd7, 1'b0, 1'b0);
      srst_n_i = 1'b0;
      tick();
      exp_err = 0;
      checks++;
      if (outs_obs !== 38'd0) $display("FAIL reset_mid_packet got=%h required=0", outs_obs);
      else passed++;
      srst_n_i = 1'b1;
      tick();
      stat_ready_i = 1'b0;
      w = '{9, 1};
      send_pkt(w, 0);
      srst_n_i = 1'b0;
      tick();
      checks++;
      if (outs_obs !== 38'd0) $display("FAIL reset_mid_hold got=%h required=0", outs_obs);
      else passed++;
      srst_n_i     = 1'b1;
      stat_ready_i = 1'b1;
      tick();
      w = '{5};
      send_pkt(w, 0);
      checks++;
      if ({stat_valid_o, rec_obs} !== {1'b1, 4'd5, 4'd5, 7'd5, 3'd1, 1'b1, 1'b0})
         $display("FAIL pkt_after_reset got=%b_%h required=1_%h", stat_valid_o, rec_obs,
                  {4'd5, 4'd5, 7'd5, 3'd1, 1'b1, 1'b0});
      else passed++;
      tick();
   endtask

   initial begin
      srst_n_i            = 1'b0;
      snk_data_i          = 4'd0;
      snk_valid_i         = 1'b0;
      snk_startofpacket_i = 1'b0;
      snk_endofpacket_i   = 1'b0;
      stat_ready_i        = 1'b1;
      test_reset();
      test_sorted();
      test_unsorted_single();
      test_trunc();
      test_backpressure();
      test_protocol();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
